// File: rtl/gmii_pkg.sv
// Shared GMII receive/transmit constants, deframer state encoding and the
// byte-wide reflected CRC-32 update used by the FCS logic.
package gmii_pkg;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_FLUSH,
    ST_DROP
  } deframe_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first CRC-32 over one byte; register is kept reflected, no inversion.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    logic [31:0] p;
    p = reflect32(CRC32_POLY);
    c = crc ^ {24'h000000, din};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8_reg.sv
// Byte-wide CRC-32 register with synchronous re-init and update enable;
// shared by the receive checker and the transmit FCS inserter.
module crc32_d8_reg
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc32_d8(crc, din);
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: hunts preamble/SFD, strips it and the FCS, checks
// CRC-32 and length, and streams dmac..payload with a per-frame status strobe.
module gmii_rx_deframer
  import gmii_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MIN_FRAME    = 64,
  parameter int unsigned MAX_FRAME    = 1518,
  parameter int unsigned LENW         = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      rxd,
  input  logic            rx_dv,
  input  logic            rx_er,
  output logic [7:0]      data,
  output logic            dven,
  output logic            sof,
  output logic            done,
  output logic            frame_ok,
  output logic [LENW-1:0] frame_len,
  output logic [15:0]     cnt_good,
  output logic [15:0]     cnt_bad
);

  localparam int unsigned PCW = 4;
  localparam logic [PCW-1:0] PRE_MAX = '1;

  deframe_state_t state, state_nx;

  logic [7:0]       r_d;
  logic             r_dv;
  logic             r_er;
  logic [PCW-1:0]   pre_cnt;
  logic [LENW-1:0]  byte_cnt;
  logic [LENW-1:0]  emit_cnt;
  logic [2:0]       fill;
  logic [3:0][7:0]  dl;
  logic             bad;
  logic [31:0]      crc;

  logic sfd_c, take_c, emit_c, ovf_c, done_c, ok_c, pre_load_c, pre_inc_c;

  crc32_d8_reg u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (sfd_c),
    .en      (take_c),
    .din     (r_d),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state and per-cycle control, all decided on the registered input byte.
  always_comb begin
    state_nx   = state;
    sfd_c      = 1'b0;
    take_c     = 1'b0;
    ovf_c      = 1'b0;
    done_c     = 1'b0;
    ok_c       = 1'b0;
    pre_load_c = 1'b0;
    pre_inc_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (r_dv) begin
          if (r_d == GMII_PREAMBLE) begin
            state_nx   = ST_PRE;
            pre_load_c = 1'b1;
          end else begin
            state_nx = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!r_dv) begin
          state_nx = ST_IDLE;
        end else if (r_d == GMII_PREAMBLE) begin
          pre_inc_c = (pre_cnt != PRE_MAX);
        end else if (r_d == GMII_SFD && pre_cnt >= PCW'(MIN_PREAMBLE)) begin
          state_nx = ST_DATA;
          sfd_c    = 1'b1;
        end else begin
          state_nx = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!r_dv) begin
          state_nx = ST_FLUSH;
          done_c   = 1'b1;
          ok_c     = !bad && (crc == CRC32_RESIDUE) && (byte_cnt >= LENW'(MIN_FRAME));
        end else if (byte_cnt == LENW'(MAX_FRAME)) begin
          state_nx = ST_DROP;
          ovf_c    = 1'b1;
        end else begin
          take_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (r_dv && r_d == GMII_PREAMBLE) begin
          state_nx   = ST_PRE;
          pre_load_c = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!r_dv) begin
          state_nx = ST_IDLE;
          done_c   = (byte_cnt != '0);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    emit_c = take_c && (fill == 3'd4);
  end

  // Input register, preamble counter, 4-byte FCS holdback line and frame bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d      <= '0;
      r_dv     <= 1'b0;
      r_er     <= 1'b0;
      pre_cnt  <= '0;
      byte_cnt <= '0;
      emit_cnt <= '0;
      fill     <= '0;
      dl       <= '0;
      bad      <= 1'b0;
    end else begin
      r_d  <= rxd;
      r_dv <= rx_dv;
      r_er <= rx_er;
      if (pre_load_c)     pre_cnt <= PCW'(1);
      else if (pre_inc_c) pre_cnt <= pre_cnt + PCW'(1);
      if (sfd_c) begin
        byte_cnt <= '0;
        emit_cnt <= '0;
        fill     <= '0;
        bad      <= 1'b0;
      end else begin
        if (take_c) begin
          byte_cnt <= byte_cnt + LENW'(1);
          dl       <= {dl[2:0], r_d};
          if (fill != 3'd4) fill <= fill + 3'd1;
        end
        if (emit_c) emit_cnt <= emit_cnt + LENW'(1);
        if (ovf_c || (state == ST_DATA && r_er)) bad <= 1'b1;
        if (done_c) byte_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      dven      <= 1'b0;
      sof       <= 1'b0;
      done      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_len <= '0;
      cnt_good  <= '0;
      cnt_bad   <= '0;
    end else begin
      dven <= emit_c;
      data <= emit_c ? dl[3] : 8'h00;
      sof  <= emit_c && (emit_cnt == '0);
      done <= done_c;
      if (done_c) begin
        frame_ok  <= ok_c;
        frame_len <= emit_cnt;
        if (ok_c) cnt_good <= cnt_good + 16'd1;
        else      cnt_bad  <= cnt_bad + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: table of framed vectors with a
// bench-side CRC-32 model, plus back-to-back and mid-frame reset sequences.
module tb_gmii_rx_deframer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  data;
  logic        dven, sof, done, frame_ok;
  logic [10:0] frame_len;
  logic [15:0] cnt_good, cnt_bad;

  gmii_rx_deframer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .data      (data),
    .dven      (dven),
    .sof       (sof),
    .done      (done),
    .frame_ok  (frame_ok),
    .frame_len (frame_len),
    .cnt_good  (cnt_good),
    .cnt_bad   (cnt_bad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor
  logic [7:0]  got_q[$];
  int          sof_idx[$];
  int          n_done = 0, n_ok = 0, n_sof = 0, overlap = 0;
  int          sof_cyc = 0, done_cyc = 0, last_dven_cyc = 0;
  logic        got_ok = 1'b0;
  logic [10:0] got_len = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sof) begin
        n_sof++;
        sof_idx.push_back(got_q.size());
        sof_cyc = cyc;
      end
      if (dven) begin
        got_q.push_back(data);
        last_dven_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        got_ok   = frame_ok;
        got_len  = frame_len;
        if (frame_ok) n_ok++;
        if (dven) overlap++;
      end
    end
  end

  task automatic clear_mon();
    got_q.delete();
    sof_idx.delete();
    n_done = 0;
    n_ok = 0;
    n_sof = 0;
    overlap = 0;
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // Frame body (dmac..FCS) to transmit
  logic [7:0] tx_q[$];

  task automatic make_frame(input int len, input int seed);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    tx_q.delete();
    if (len < 4) begin
      for (int i = 0; i < len; i++) tx_q.push_back(8'(i + seed));
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
        if (i < 6)        b = 8'hFF;
        else if (i == 12) b = 8'h08;
        else if (i == 13) b = 8'h06;
        else              b = 8'(i * 7 + seed);
        tx_q.push_back(b);
        c = crc_bits(c, b);
      end
      fcs = ~c;
      tx_q.push_back(fcs[7:0]);
      tx_q.push_back(fcs[15:8]);
      tx_q.push_back(fcs[23:16]);
      tx_q.push_back(fcs[31:24]);
    end
  endtask

  int first_cyc = 0, last_cyc = 0;

  task automatic drive_frame(input int npre, input logic [7:0] sfd, input int er_at, input int gap);
    for (int i = 0; i < npre; i++) begin
      @(negedge clk);
      rxd = 8'h55; rx_dv = 1'b1; rx_er = 1'b0;
    end
    @(negedge clk);
    rxd = sfd; rx_dv = 1'b1; rx_er = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      rxd   = tx_q[i];
      rx_er = (i == er_at);
      if (i == 0) first_cyc = cyc;
      if (i == tx_q.size() - 1) last_cyc = cyc;
    end
    @(negedge clk);
    rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  typedef struct {
    int         npre;
    logic [7:0] sfd;
    int         len;
    int         flip;
    int         er_at;
    int         exp_done;
    int         exp_ok;
    int         exp_len;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  int exp_good = 0, exp_bad = 0;
  logic [7:0] exp_q[$];

  initial begin
    int mism;
    int exp_sof;
    vt[0]  = '{7, 8'hD5,   64, -1, -1, 1, 1,   60};
    vt[1]  = '{7, 8'hD5,   64, 25, -1, 1, 0,   60};
    vt[2]  = '{7, 8'hD5,   64, -1, 30, 1, 0,   60};
    vt[3]  = '{7, 8'hD5,   20, -1, -1, 1, 0,   16};
    vt[4]  = '{3, 8'h12,   64, -1, -1, 0, 0,    0};
    vt[5]  = '{7, 8'hD5,   64, -1, -1, 1, 1,   60};
    vt[6]  = '{1, 8'hD5,   64, -1, -1, 1, 1,   60};
    vt[7]  = '{0, 8'hD5,   64, -1, -1, 0, 0,    0};
    vt[8]  = '{7, 8'hD5,   63, -1, -1, 1, 0,   59};
    vt[9]  = '{7, 8'hD5,    3, -1, -1, 1, 0,    0};
    vt[10] = '{7, 8'hD5,    4, -1, -1, 1, 0,    0};
    vt[11] = '{7, 8'hD5, 1518, -1, -1, 1, 1, 1514};
    vt[12] = '{7, 8'hD5, 1519, -1, -1, 1, 0, 1514};

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({dven, sof, done, frame_ok, frame_len, data, cnt_good, cnt_bad}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      make_frame(vt[v].len, v * 13 + 1);
      if (vt[v].flip >= 0) tx_q[vt[v].flip] = tx_q[vt[v].flip] ^ 8'h01;
      clear_mon();
      drive_frame(vt[v].npre, vt[v].sfd, vt[v].er_at, 1);
      repeat (8) @(negedge clk);
      if (vt[v].exp_done != 0) begin
        if (vt[v].exp_ok != 0) exp_good++;
        else                   exp_bad++;
      end
      check($sformatf("v%0d_done_count", v), 64'(n_done), 64'(vt[v].exp_done));
      if (vt[v].exp_done != 0) begin
        check($sformatf("v%0d_frame_ok", v), 64'(got_ok), 64'(vt[v].exp_ok));
        check($sformatf("v%0d_frame_len", v), 64'(got_len), 64'(vt[v].exp_len));
      end
      check($sformatf("v%0d_byte_count", v), 64'(got_q.size()), 64'(vt[v].exp_len));
      mism = 0;
      for (int i = 0; i < got_q.size() && i < vt[v].exp_len; i++)
        if (got_q[i] !== tx_q[i]) mism++;
      check($sformatf("v%0d_data_mismatches", v), 64'(mism), 64'd0);
      exp_sof = (vt[v].exp_len > 0) ? 1 : 0;
      check($sformatf("v%0d_sof_count", v), 64'(n_sof), 64'(exp_sof));
      if (sof_idx.size() > 0) check($sformatf("v%0d_sof_pos", v), 64'(sof_idx[0]), 64'd0);
      check($sformatf("v%0d_cnt_good", v), 64'(cnt_good), 64'(exp_good));
      check($sformatf("v%0d_cnt_bad", v), 64'(cnt_bad), 64'(exp_bad));
      if (vt[v].exp_ok != 0) begin
        check($sformatf("v%0d_sof_latency", v), 64'(sof_cyc - first_cyc), 64'd6);
        check($sformatf("v%0d_last_latency", v), 64'(last_dven_cyc - last_cyc), 64'd2);
        check($sformatf("v%0d_done_after_last", v), 64'(done_cyc - last_dven_cyc), 64'd1);
      end
    end

    // Two good frames separated by a single idle cycle
    clear_mon();
    make_frame(64, 3);
    exp_q = tx_q[0:59];
    drive_frame(7, 8'hD5, -1, 1);
    make_frame(64, 9);
    for (int i = 0; i < 60; i++) exp_q.push_back(tx_q[i]);
    drive_frame(7, 8'hD5, -1, 1);
    repeat (8) @(negedge clk);
    exp_good += 2;
    check("b2b_done_count", 64'(n_done), 64'd2);
    check("b2b_ok_count", 64'(n_ok), 64'd2);
    check("b2b_byte_count", 64'(got_q.size()), 64'd120);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < 120; i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check("b2b_data_mismatches", 64'(mism), 64'd0);
    check("b2b_sof_count", 64'(sof_idx.size()), 64'd2);
    if (sof_idx.size() == 2) check("b2b_sof2_pos", 64'(sof_idx[1]), 64'd60);
    check("b2b_done_dven_overlap", 64'(overlap), 64'd0);
    check("b2b_cnt_good", 64'(cnt_good), 64'(exp_good));

    // Reset asserted while byte 30 of a frame is on the wire
    make_frame(64, 41);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rxd = 8'h55; rx_dv = 1'b1;
    end
    @(negedge clk);
    rxd = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rxd = tx_q[i];
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({dven, sof, done, frame_ok, frame_len, data, cnt_good, cnt_bad}), 64'd0);
    rx_dv = 1'b0;
    rxd = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    make_frame(64, 5);
    drive_frame(7, 8'hD5, -1, 1);
    repeat (8) @(negedge clk);
    check("post_reset_done_count", 64'(n_done), 64'd1);
    check("post_reset_frame_ok", 64'(got_ok), 64'd1);
    check("post_reset_cnt_good", 64'(cnt_good), 64'd1);
    check("post_reset_cnt_bad", 64'(cnt_bad), 64'd0);
    check("post_reset_byte_count", 64'(got_q.size()), 64'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
